// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, default bit timing and transmitter FSM encoding.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS            = 8;
   localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of a bit.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == CntMax);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 (or 8N2) UART transmitter with valid/ready byte input and a registered serial output.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [UART_DATA_BITS-1:0] tx_data_i,
   input  logic                      tx_valid_i,
   output logic                      tx_ready_o,
   output logic                      tx_busy_o,
   output logic                      uart_sout_o
);

   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : gen_bad_clks_per_bit
      $error("uart_tx: CLKS_PER_BIT must be in 2..65535");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : gen_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   localparam logic StopLast = 1'(STOP_BITS - 1);

   uart_state_e               state_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [2:0]                bit_cnt_q;
   logic                      stop_cnt_q;
   logic                      sout_q;
   logic                      ready_q;
   logic                      busy_q;
   logic                      accept;
   logic                      baud_tick;

   assign accept = tx_valid_i && ready_q;

   // Counter runs for the whole frame; it wraps itself at each bit boundary.
   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (accept),
      .en_i  (busy_q),
      .tick_o(baud_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         sout_q     <= 1'b1;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  shift_q    <= tx_data_i;
                  bit_cnt_q  <= '0;
                  stop_cnt_q <= 1'b0;
                  sout_q     <= 1'b0;
                  ready_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= StStart;
               end
            end
            StStart: begin
               if (baud_tick) begin
                  sout_q  <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  state_q <= StData;
               end
            end
            StData: begin
               if (baud_tick) begin
                  if (bit_cnt_q == 3'd7) begin
                     sout_q  <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     sout_q    <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
               end
            end
            StStop: begin
               if (baud_tick) begin
                  if (stop_cnt_q == StopLast) begin
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     stop_cnt_q <= stop_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign uart_sout_o = sout_q;
   assign tx_ready_o  = ready_q;
   assign tx_busy_o   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames, reset cases and a mid-bit model receiver.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data1, data2;
   logic       valid1, valid2;
   logic       ready1, ready2, busy1, busy2, sout1, sout2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .tx_data_i(data1), .tx_valid_i(valid1),
      .tx_ready_o(ready1), .tx_busy_o(busy1), .uart_sout_o(sout1)
   );

   uart_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .tx_data_i(data2), .tx_valid_i(valid2),
      .tx_ready_o(ready2), .tx_busy_o(busy2), .uart_sout_o(sout2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line level k cycles after the acceptance edge: start, 8 data bits LSB first, stop.
   function automatic logic exp_bit(input logic [7:0] d, input int k, input int c);
      int idx;
      idx = k / c;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      chk("busy_inv1", busy1, !ready1);
      chk("busy_inv2", busy2, !ready2);
   end

   // Leaves the caller at sample index 0 (first negedge after acceptance).
   task automatic send1(input logic [7:0] d);
      @(negedge clk);
      data1  = d;
      valid1 = 1'b1;
      @(negedge clk);
      valid1 = 1'b0;
      data1  = ~d;
   endtask

   task automatic check_frame1(input logic [7:0] d);
      for (int k = 0; k < 40; k++) begin
         chk("frame_sout", sout1, exp_bit(d, k, 4));
         chk("frame_ready_low", ready1, 1'b0);
         @(negedge clk);
      end
      chk("frame_ready_ret", ready1, 1'b1);
      chk("frame_idle_sout", sout1, 1'b1);
   endtask

   logic       samp [0:39];
   logic [7:0] d, rx;
   logic       prev, obs, exp_s, exp_r;
   int         nfall;

   initial begin
      rst_n  = 1'b1;
      data1  = '0;
      data2  = '0;
      valid1 = 1'b0;
      valid2 = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_sout", sout1, 1'b1);
      chk("rst_ready", ready1, 1'b1);
      chk("rst_busy", busy1, 1'b0);
      chk("rst_sout2", sout2, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single byte A5
      send1(8'hA5);
      check_frame1(8'hA5);

      // Held valid, data changes mid-frame and on the ready cycle
      @(negedge clk);
      data1  = 8'h00;
      valid1 = 1'b1;
      @(negedge clk);
      nfall = 0;
      prev  = 1'b1;
      for (int k = 0; k < 100; k++) begin
         obs = sout1;
         if (k < 40)       begin exp_s = exp_bit(8'h00, k, 4);      exp_r = 1'b0; end
         else if (k == 40) begin exp_s = 1'b1;                      exp_r = 1'b1; end
         else if (k < 81)  begin exp_s = exp_bit(8'hFF, k - 41, 4); exp_r = 1'b0; end
         else              begin exp_s = 1'b1;                      exp_r = 1'b1; end
         chk("hv_sout", obs, exp_s);
         chk("hv_ready", ready1, exp_r);
         if (prev && !obs) nfall++;
         prev = obs;
         if (k == 20) data1 = 8'h5A;
         if (k == 40) data1 = 8'hFF;
         if (k == 41) valid1 = 1'b0;
         @(negedge clk);
      end
      chk("hv_frames", nfall, 2);

      // Two stop bits, 3 clocks per bit
      @(negedge clk);
      data2  = 8'h81;
      valid2 = 1'b1;
      @(negedge clk);
      valid2 = 1'b0;
      for (int k = 0; k < 33; k++) begin
         chk("sb2_sout", sout2, exp_bit(8'h81, k, 3));
         chk("sb2_ready_low", ready2, 1'b0);
         @(negedge clk);
      end
      chk("sb2_ready_ret", ready2, 1'b1);
      chk("sb2_idle_sout", sout2, 1'b1);

      // Reset at cycle 15 of a frame, then a clean frame
      send1(8'h00);
      repeat (15) @(negedge clk);
      chk("mid_pre_sout", sout1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sout", sout1, 1'b1);
      chk("mid_rst_ready", ready1, 1'b1);
      chk("mid_rst_busy", busy1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      send1(8'h3C);
      check_frame1(8'h3C);

      // Random bytes through a mid-bit sampling receiver
      for (int i = 0; i < 256; i++) begin
         d = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom);
         send1(d);
         for (int k = 0; k < 40; k++) begin
            samp[k] = sout1;
            @(negedge clk);
         end
         rx = '0;
         for (int b = 0; b < 8; b++) rx[b] = samp[4 * (b + 1) + 2];
         chk("rx_start", samp[2], 1'b0);
         chk("rx_stop", samp[38], 1'b1);
         chk("rx_data", rx, d);
         chk("rx_ready", ready1, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
